tdd_frame_ctrl: RTL and testbench
=================================

TDD_FRAME_CTRL -- requirements
Module: tdd_frame_ctrl

Interface
REQ-001 SHALL have parameter FW, default 24, giving the width of all sample-count and window ports.
REQ-002 SHALL have port clk, input, 1: sample clock, the same clock that drives the AXI2S stream side.
REQ-003 SHALL have port rst, input, 1: synchronous active-high reset.
REQ-004 SHALL have port en, input, 1: global run enable.
REQ-005 SHALL have port frame_len, input, FW: frame length in samples.
REQ-006 SHALL have ports rstart and rend, input, FW each: receive window; first sample and one-past-last sample.
REQ-007 SHALL have ports tstart and tend, input, FW each: transmit window, same convention as receive.
REQ-008 SHALL have ports adj_req (input, 1: one-cycle request strobe) and frame_adj (input, FW: two's-complement length offset).
REQ-009 SHALL have port adj_pending, output, 1: an adjust request is accepted but not yet applied.
REQ-010 SHALL have ports ien and oen, output, 1 each: receive and transmit enables, driving AXI2S Ien and Oen.
REQ-011 SHALL have port sync, output, 1: one-cycle pulse on the first sample of each frame.
REQ-012 SHALL have port fcnt, output, FW: sample index within the current frame.
REQ-013 SHALL have port frame_no, output, 32: count of started frames.

Function
REQ-014 SHALL count fcnt from 0 to L-1, then wrap to 0, where L is the effective length latched at frame start.
REQ-015 SHALL latch frame_len, all four window bounds and L into shadow registers on every frame start; mid-frame input changes SHALL NOT affect the current frame.
REQ-016 SHALL set L = frame_len, and SHALL force L = 2 whenever the computed length is below 2.
REQ-017 SHALL treat a window (s, e) as active when s <= fcnt < e if s < e; when fcnt >= s or fcnt < e if s > e (wrap-around); never if s == e.
REQ-018 SHALL register ien, oen and sync so they are cycle-aligned with the fcnt value they describe.
REQ-019 SHALL assert sync on every cycle where fcnt == 0 at a frame start, including the first frame after en rises.
REQ-020 SHALL, on adj_req while adj_pending == 0, latch frame_adj and set adj_pending on the next cycle.
REQ-021 SHALL ignore adj_req while adj_pending == 1.
REQ-022 SHALL apply an accepted adjust to the next frame start only (L = frame_len + frame_adj, clamped per REQ-016), and SHALL clear adj_pending on that frame-start cycle.
REQ-023 SHALL defer an adj_req that arrives on the last cycle of a frame (fcnt == L-1) to the following frame boundary.
REQ-024 SHALL affect only one frame per adjust; the frame after the adjusted one SHALL revert to frame_len.
REQ-025 SHALL, on en low, on the next cycle hold fcnt at 0, drive ien, oen and sync low, and keep adj_pending and frame_no unchanged.
REQ-026 SHALL start a new frame with sync on the first cycle after en returns high.

Reset
REQ-027 SHALL drive fcnt = 0, ien = 0, oen = 0, sync = 0, adj_pending = 0 and frame_no = 0 on the cycle after rst is sampled high.
REQ-028 SHALL clear all shadow registers and the latched adjust on reset; a reset mid-frame SHALL abandon that frame and discard any pending adjust.

Configuration
REQ-029 SHALL compile the frame_no counter in when macro TDD_FRAME_CNT_EN is defined: frame_no increments by 1 on each sync and wraps from 0xFFFFFFFF to 0.
REQ-030 SHALL, without TDD_FRAME_CNT_EN, tie frame_no to 0 and omit its register.

Verification
REQ-031 SHALL check: frame_len = 10, rstart = 2, rend = 5, en high -> ien high at fcnt 2..4 only; sync at fcnt 0; period 10.
REQ-032 SHALL check: tstart = 8, tend = 2, frame_len = 10 -> oen high at fcnt 8, 9, 0 and 1 (wrap window).
REQ-033 SHALL check: frame_adj = -3 pulsed at fcnt 4 -> adj_pending high until the next sync, that frame is 7 samples, the following frame is 10.
REQ-034 SHALL check: second adj_req while pending -> ignored; adj_req at fcnt 9 -> applied one frame later.
REQ-035 SHALL check: frame_len = 1 or frame_adj = -20 -> frame length of 2; rstart == rend -> ien never asserts.
REQ-036 SHALL check: rst at fcnt 6 with an adjust pending -> all outputs 0 next cycle, adjust discarded; en drop then rise -> sync and fcnt 0, frame_no continues (TDD_FRAME_CNT_EN defined).

Source files
------------

// File: rtl/tdd_frame_ctrl.sv
// TDD frame timing controller: frame counter, shadowed RX/TX windows, one-shot length adjust.
// Optional frame_no counter is compiled in with `define TDD_FRAME_CNT_EN.
module tdd_frame_ctrl #(
  parameter int FW = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [FW-1:0] frame_len,
  input  logic [FW-1:0] rstart,
  input  logic [FW-1:0] rend,
  input  logic [FW-1:0] tstart,
  input  logic [FW-1:0] tend,
  input  logic          adj_req,
  input  logic [FW-1:0] frame_adj,
  output logic          adj_pending,
  output logic          ien,
  output logic          oen,
  output logic          sync,
  output logic [FW-1:0] fcnt,
  output logic [31:0]   frame_no
);

  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [FW-1:0] len_q, len_d;
  logic [FW-1:0] rs_q, rs_d, re_q, re_d;
  logic [FW-1:0] ts_q, ts_d, te_q, te_d;
  logic [FW-1:0] adj_val_q, adj_val_d;
  logic          adj_pend_q, adj_pend_d;
  logic          run_q, run_d;
  logic          sync_q, sync_d;
  logic          ien_q, ien_d;
  logic          oen_q, oen_d;

  logic [FW+1:0] adj_ext;
  logic [FW+1:0] len_sum;
  logic [FW-1:0] len_new;

  function automatic logic win_active(input logic [FW-1:0] s, input logic [FW-1:0] e,
                                      input logic [FW-1:0] c);
    logic act;
    act = 1'b0;
    if (s < e)      act = (c >= s) && (c < e);
    else if (s > e) act = (c >= s) || (c < e);
    return act;
  endfunction

  // Extra headroom bits so a negative sum and an overflow are both visible before clamping.
  always_comb begin
    adj_ext = adj_pend_q ? {{2{adj_val_q[FW-1]}}, adj_val_q} : '0;
    len_sum = {2'b00, frame_len} + adj_ext;
    if (len_sum[FW+1] || (len_sum < (FW+2)'(2))) len_new = FW'(2);
    else if (len_sum[FW])                        len_new = '1;
    else                                         len_new = len_sum[FW-1:0];
  end

  always_comb begin
    fcnt_d     = fcnt_q;
    len_d      = len_q;
    rs_d       = rs_q;
    re_d       = re_q;
    ts_d       = ts_q;
    te_d       = te_q;
    adj_val_d  = adj_val_q;
    adj_pend_d = adj_pend_q;
    run_d      = run_q;
    sync_d     = 1'b0;
    ien_d      = 1'b0;
    oen_d      = 1'b0;

    if (adj_req && !adj_pend_q) begin
      adj_val_d  = frame_adj;
      adj_pend_d = 1'b1;
    end

    if (!en) begin
      run_d  = 1'b0;
      fcnt_d = '0;
    end else begin
      run_d = 1'b1;
      if (!run_q || (fcnt_q == len_q - FW'(1))) begin
        fcnt_d = '0;
        len_d  = len_new;
        rs_d   = rstart;
        re_d   = rend;
        ts_d   = tstart;
        te_d   = tend;
        sync_d = 1'b1;
        if (adj_pend_q) adj_pend_d = 1'b0;
      end else begin
        fcnt_d = fcnt_q + FW'(1);
      end
      // Windows are evaluated on the next count so the registered enables line up with fcnt.
      ien_d = win_active(rs_d, re_d, fcnt_d);
      oen_d = win_active(ts_d, te_d, fcnt_d);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt_q     <= '0;
      len_q      <= '0;
      rs_q       <= '0;
      re_q       <= '0;
      ts_q       <= '0;
      te_q       <= '0;
      adj_val_q  <= '0;
      adj_pend_q <= 1'b0;
      run_q      <= 1'b0;
      sync_q     <= 1'b0;
      ien_q      <= 1'b0;
      oen_q      <= 1'b0;
    end else begin
      fcnt_q     <= fcnt_d;
      len_q      <= len_d;
      rs_q       <= rs_d;
      re_q       <= re_d;
      ts_q       <= ts_d;
      te_q       <= te_d;
      adj_val_q  <= adj_val_d;
      adj_pend_q <= adj_pend_d;
      run_q      <= run_d;
      sync_q     <= sync_d;
      ien_q      <= ien_d;
      oen_q      <= oen_d;
    end
  end

`ifdef TDD_FRAME_CNT_EN
  logic [31:0] frame_no_q, frame_no_d;

  always_comb frame_no_d = sync_d ? frame_no_q + 32'd1 : frame_no_q;

  always_ff @(posedge clk) begin
    if (rst) frame_no_q <= '0;
    else     frame_no_q <= frame_no_d;
  end

  assign frame_no = frame_no_q;
`else
  assign frame_no = '0;
`endif

  assign fcnt        = fcnt_q;
  assign sync        = sync_q;
  assign ien         = ien_q;
  assign oen         = oen_q;
  assign adj_pending = adj_pend_q;

endmodule

// File: tb/tb_tdd_frame_ctrl.sv
// Scoreboard bench for tdd_frame_ctrl: expected frame descriptors queued by stimulus, checked per observed frame.
module tb_tdd_frame_ctrl;
  localparam int FW = 24;
  localparam int NF = 15;
  localparam int LAST_T = 113;

  logic          clk = 1'b0;
  logic          rst, en, adj_req;
  logic [FW-1:0] frame_len, rstart, rend, tstart, tend, frame_adj;
  logic          adj_pending, ien, oen, sync;
  logic [FW-1:0] fcnt;
  logic [31:0]   frame_no;

  tdd_frame_ctrl #(.FW(FW)) dut (
    .clk(clk), .rst(rst), .en(en), .frame_len(frame_len),
    .rstart(rstart), .rend(rend), .tstart(tstart), .tend(tend),
    .adj_req(adj_req), .frame_adj(frame_adj), .adj_pending(adj_pending),
    .ien(ien), .oen(oen), .sync(sync), .fcnt(fcnt), .frame_no(frame_no)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] len;
    logic [31:0] ien_m;
    logic [31:0] oen_m;
    logic [31:0] pend_m;
    logic [31:0] fn;
  } frame_t;

  frame_t exp_q[$];
  frame_t exp_tab[NF];
  int     start_t[NF] = '{0, 10, 20, 27, 37, 47, 54, 64, 66, 68, 70, 78, 88, 95, 102};

  int n_tests = 0;
  int n_fail  = 0;
  int frames_seen = 0;

  function automatic logic [31:0] fn_exp(input int n);
`ifdef TDD_FRAME_CNT_EN
    return 32'(n);
`else
    return 32'(n * 0);
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic frame_t mk(input int len, input int im, input int om, input int pm, input int fn);
    frame_t f;
    f.len = 32'(len); f.ien_m = 32'(im); f.oen_m = 32'(om); f.pend_m = 32'(pm); f.fn = fn_exp(fn);
    return f;
  endfunction

  // Monitor: accumulate one frame from sync until the next sync or idle (fcnt back to 0).
  logic        in_frame = 1'b0;
  int          idx;
  logic        seq_ok;
  logic [31:0] o_ien, o_oen, o_pend, o_fn;

  task automatic finalize();
    frame_t e;
    frames_seen++;
    if (exp_q.size() == 0) begin
      check($sformatf("unexpected_frame_%0d", frames_seen), 32'(idx), 32'hFFFF_FFFF);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("f%0d_len", frames_seen),      32'(idx), e.len);
      check($sformatf("f%0d_ien", frames_seen),      o_ien,    e.ien_m);
      check($sformatf("f%0d_oen", frames_seen),      o_oen,    e.oen_m);
      check($sformatf("f%0d_pending", frames_seen),  o_pend,   e.pend_m);
      check($sformatf("f%0d_frame_no", frames_seen), o_fn,     e.fn);
      check($sformatf("f%0d_fcnt_seq", frames_seen), 32'(seq_ok), 32'd1);
    end
  endtask

  always @(negedge clk) begin
    if (in_frame && (sync === 1'b1 || fcnt === '0)) begin
      finalize();
      in_frame = 1'b0;
    end
    if (sync === 1'b1) begin
      in_frame = 1'b1;
      idx = 0; seq_ok = 1'b1;
      o_ien = '0; o_oen = '0; o_pend = '0;
      o_fn = frame_no;
    end
    if (in_frame) begin
      if (fcnt !== FW'(idx)) seq_ok = 1'b0;
      if (idx < 32) begin
        if (ien === 1'b1)         o_ien[idx]  = 1'b1;
        if (oen === 1'b1)         o_oen[idx]  = 1'b1;
        if (adj_pending === 1'b1) o_pend[idx] = 1'b1;
      end
      idx++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_tab[0]  = mk(10, 'h1C, 'h303, 'h000, 1);
    exp_tab[1]  = mk(10, 'h1C, 'h303, 'h3E0, 2);
    exp_tab[2]  = mk(7,  'h1C, 'h003, 'h000, 3);
    exp_tab[3]  = mk(10, 'h1C, 'h303, 'h000, 4);
    exp_tab[4]  = mk(10, 'h1C, 'h303, 'h3FF, 5);
    exp_tab[5]  = mk(7,  'h1C, 'h003, 'h000, 6);
    exp_tab[6]  = mk(10, 'h1C, 'h303, 'h000, 7);
    exp_tab[7]  = mk(2,  'h00, 'h003, 'h000, 8);
    exp_tab[8]  = mk(2,  'h00, 'h003, 'h002, 9);
    exp_tab[9]  = mk(2,  'h00, 'h003, 'h000, 10);
    exp_tab[10] = mk(7,  'h1C, 'h003, 'h078, 11);
    exp_tab[11] = mk(10, 'h1C, 'h303, 'h000, 1);
    exp_tab[12] = mk(4,  'h0C, 'h003, 'h00C, 2);
    exp_tab[13] = mk(7,  'h1C, 'h003, 'h000, 3);
    exp_tab[14] = mk(10, 'h1C, 'h303, 'h000, 4);

    rst = 1'b1; en = 1'b0; adj_req = 1'b0; frame_adj = '0;
    frame_len = FW'(10); rstart = FW'(2); rend = FW'(5); tstart = FW'(8); tend = FW'(2);
    repeat (3) step();
    check("reset_fcnt", 32'(fcnt), 32'd0);
    check("reset_outs", {28'd0, ien, oen, sync, adj_pending}, 32'd0);
    check("reset_frame_no", frame_no, 32'd0);

    rst = 1'b0; en = 1'b1;
    step();
    for (int t = 0; t <= LAST_T; t++) begin
      for (int k = 0; k < NF; k++)
        if (start_t[k] == t) exp_q.push_back(exp_tab[k]);
      if (t == 77) begin
        check("rst_fcnt", 32'(fcnt), 32'd0);
        check("rst_outs", {28'd0, ien, oen, sync, adj_pending}, 32'd0);
        check("rst_frame_no", frame_no, 32'd0);
      end
      if (t == 92) begin
        check("en_low_fcnt", 32'(fcnt), 32'd0);
        check("en_low_outs", {29'd0, ien, oen, sync}, 32'd0);
        check("en_low_pending", 32'(adj_pending), 32'd1);
        check("en_low_frame_no", frame_no, fn_exp(2));
      end
      case (t)
        14: begin adj_req = 1'b1; frame_adj = -FW'(3); end
        16: begin adj_req = 1'b1; frame_adj = FW'(5); end
        36: begin adj_req = 1'b1; frame_adj = -FW'(3); end
        58: begin frame_len = FW'(1); rstart = FW'(3); rend = FW'(3); end
        66: begin
          frame_len = FW'(10); rstart = FW'(2); rend = FW'(5);
          adj_req = 1'b1; frame_adj = -FW'(20);
        end
        72: begin adj_req = 1'b1; frame_adj = -FW'(3); end
        76: rst = 1'b1;
        77: rst = 1'b0;
        89: begin adj_req = 1'b1; frame_adj = -FW'(3); end
        91: en = 1'b0;
        94: en = 1'b1;
        default: adj_req = 1'b0;
      endcase
      step();
    end

    check("frames_observed", 32'(frames_seen), 32'(NF));
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
